// File: rtl/disk_if_pkg.sv
// Shared definitions for the disk controller SPI link: opcodes, fill bytes,
// bridge state encoding and the byte-counter helper.
package disk_if_pkg;

    localparam logic [7:0] OP_STATUS = 8'h01;
    localparam logic [7:0] OP_CTRL   = 8'h02;
    localparam logic [7:0] OP_WRDATA = 8'h03;
    localparam logic [7:0] OP_RDDATA = 8'h04;

    localparam logic [7:0] FILL_CMD  = 8'h00;
    localparam logic [7:0] FILL_IDLE = 8'hFF;

    localparam int BYTE_CNT_W = 10;
    localparam logic [BYTE_CNT_W-1:0] CTRL_BYTES = 10'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_STATUS,
        ST_CTRL,
        ST_WRDATA,
        ST_RDDATA,
        ST_DISCARD
    } bridge_state_e;

    function automatic logic [BYTE_CNT_W-1:0] sat_inc(
        input logic [BYTE_CNT_W-1:0] cnt,
        input logic [BYTE_CNT_W-1:0] lim
    );
        return (cnt >= lim) ? cnt : cnt + BYTE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one SPI pin with rise/fall pulses in the clk
// domain; IDLE_LVL is the level the pin rests at while the bus is quiet.
module spi_sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/disk_spi_bridge.sv
// SPI (mode 0) slave bridging an MCU to the FDC status/control words and
// sector FIFOs, fully oversampled in the clk domain.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | cs_n high, MISO parked at 1, waiting for cs_n fall
// ST_CMD     | receiving opcode byte, MISO sends 0x00
// ST_STATUS  | shifting out the disk_sr snapshot, then 0xFF
// ST_CTRL    | assembling a 4-byte disk_cr word, extra bytes ignored
// ST_WRDATA  | each received byte strobed into the FDC read FIFO
// ST_RDDATA  | each byte start pops the FDC write FIFO onto MISO
// ST_DISCARD | unknown opcode, MISO sends 0xFF, no side effects
module disk_spi_bridge
    import disk_if_pkg::*;
#(
    parameter int SECTOR_BYTES = 512,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [31:0] disk_sr,
    output logic [31:0] disk_cr,
    output logic [7:0]  disk_data_in,
    output logic        disk_data_clkin,
    input  logic [7:0]  disk_data_out,
    output logic        disk_data_clkout
);

    localparam logic [BYTE_CNT_W-1:0] SECTOR_LIM = BYTE_CNT_W'(SECTOR_BYTES);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .async_i(spi_sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .async_i(spi_cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .async_i(spi_mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_lvl, mosi_rise, mosi_fall};

    bridge_state_e         state_q;
    logic [2:0]            bit_cnt_q;
    logic [BYTE_CNT_W-1:0] byte_cnt_q;
    logic [7:0]            rx_q;
    logic [7:0]            tx_q;
    logic [31:0]           snap_q;
    logic [31:0]           cr_sh_q;
    logic [31:0]           cr_q;
    logic [7:0]            data_in_q;
    logic                  clkin_q;
    logic                  clkout_q;
    logic                  miso_q;

    logic [7:0] rx_d;
    logic       byte_done;

    assign rx_d      = {rx_q[6:0], mosi_lvl};
    assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            snap_q     <= '0;
            cr_sh_q    <= '0;
            cr_q       <= '0;
            data_in_q  <= '0;
            clkin_q    <= 1'b0;
            clkout_q   <= 1'b0;
            miso_q     <= 1'b1;
        end else begin
            clkin_q  <= 1'b0;
            clkout_q <= 1'b0;
            if (cs_rise) begin
                state_q   <= ST_IDLE;
                miso_q    <= 1'b1;
                bit_cnt_q <= '0;
            end else if (state_q == ST_IDLE) begin
                miso_q <= 1'b1;
                if (cs_fall) begin
                    state_q    <= ST_CMD;
                    bit_cnt_q  <= '0;
                    byte_cnt_q <= '0;
                    tx_q       <= FILL_CMD;
                    miso_q     <= FILL_CMD[7];
                end
            end else if (!cs_lvl) begin
                if (sclk_rise) begin
                    rx_q      <= rx_d;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                // After a byte boundary the freshly loaded MSB goes out unshifted
                if (sclk_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        miso_q <= tx_q[7];
                    end else begin
                        miso_q <= tx_q[6];
                        tx_q   <= {tx_q[6:0], 1'b0};
                    end
                end
                if (byte_done) begin
                    tx_q <= FILL_IDLE;
                    case (state_q)
                        ST_CMD: begin
                            case (rx_d)
                                OP_STATUS: begin
                                    state_q <= ST_STATUS;
                                    tx_q    <= disk_sr[31:24];
                                    snap_q  <= {disk_sr[23:0], FILL_IDLE};
                                end
                                OP_CTRL:   state_q <= ST_CTRL;
                                OP_WRDATA: state_q <= ST_WRDATA;
                                OP_RDDATA: begin
                                    state_q <= ST_RDDATA;
                                    if (byte_cnt_q < SECTOR_LIM) begin
                                        tx_q       <= disk_data_out;
                                        clkout_q   <= 1'b1;
                                        byte_cnt_q <= sat_inc(byte_cnt_q, SECTOR_LIM);
                                    end
                                end
                                default:   state_q <= ST_DISCARD;
                            endcase
                        end
                        ST_STATUS: begin
                            tx_q   <= snap_q[31:24];
                            snap_q <= {snap_q[23:0], FILL_IDLE};
                        end
                        ST_CTRL: begin
                            if (byte_cnt_q < CTRL_BYTES) begin
                                cr_sh_q    <= {cr_sh_q[23:0], rx_d};
                                byte_cnt_q <= sat_inc(byte_cnt_q, SECTOR_LIM);
                                if (byte_cnt_q == CTRL_BYTES - BYTE_CNT_W'(1)) begin
                                    cr_q <= {cr_sh_q[23:0], rx_d};
                                end
                            end
                        end
                        ST_WRDATA: begin
                            if (byte_cnt_q < SECTOR_LIM) begin
                                data_in_q  <= rx_d;
                                clkin_q    <= 1'b1;
                                byte_cnt_q <= sat_inc(byte_cnt_q, SECTOR_LIM);
                            end
                        end
                        ST_RDDATA: begin
                            if (byte_cnt_q < SECTOR_LIM) begin
                                tx_q       <= disk_data_out;
                                clkout_q   <= 1'b1;
                                byte_cnt_q <= sat_inc(byte_cnt_q, SECTOR_LIM);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign spi_miso         = miso_q;
    assign disk_cr          = cr_q;
    assign disk_data_in     = data_in_q;
    assign disk_data_clkin  = clkin_q;
    assign disk_data_clkout = clkout_q;

endmodule

// File: tb/tb_disk_spi_bridge.sv
// Self-checking bench for disk_spi_bridge: directed and random SPI frames
// compared against a frame-level model of the MCU protocol.
module tb_disk_spi_bridge;

    localparam int SECTOR = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [31:0] disk_sr = 32'h0;
    logic [31:0] disk_cr;
    logic [7:0]  disk_data_in;
    logic        disk_data_clkin;
    logic [7:0]  disk_data_out;
    logic        disk_data_clkout;

    disk_spi_bridge #(.SECTOR_BYTES(SECTOR), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .disk_sr(disk_sr), .disk_cr(disk_cr),
        .disk_data_in(disk_data_in), .disk_data_clkin(disk_data_clkin),
        .disk_data_out(disk_data_out), .disk_data_clkout(disk_data_clkout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // FDC write FIFO model: head at rd_ptr, popped by clkout
    logic [7:0] rd_src [0:2047];
    int         rd_ptr = 0;
    assign disk_data_out = rd_src[rd_ptr % 2048];

    logic [7:0] wr_q [$];
    int         both_cnt = 0;
    int         wide_cnt = 0;
    logic       clkin_prev = 1'b0;

    always @(negedge clk) begin
        if (disk_data_clkin) wr_q.push_back(disk_data_in);
        if (disk_data_clkout) rd_ptr = rd_ptr + 1;
        if (disk_data_clkin && disk_data_clkout) both_cnt = both_cnt + 1;
        if (disk_data_clkin && clkin_prev) wide_cnt = wide_cnt + 1;
        clkin_prev = disk_data_clkin;
    end

    logic [7:0]  fr      [0:599];
    logic [7:0]  miso_rx [0:599];
    logic [31:0] cr_exp = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_miso(input logic [7:0] op, input int i,
                                            input int rd_base, input logic [31:0] sr);
        logic [31:0] s;
        if (i == 0) return 8'h00;
        if (op == 8'h01) begin
            if (i <= 4) begin
                s = sr >> (8 * (4 - i));
                return s[7:0];
            end
            return 8'hFF;
        end
        if (op == 8'h04) return (i - 1 < SECTOR) ? rd_src[(rd_base + i - 1) % 2048] : 8'hFF;
        return 8'hFF;
    endfunction

    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            #50;
            r = {r[6:0], spi_miso};
            spi_sclk = 1'b1;
            #50;
            spi_sclk = 1'b0;
        end
    endtask

    // Sends fr[0] (opcode), k full data bytes and part_bits of fr[k+1], then checks
    task automatic run_frame(input int k, input int part_bits);
        logic [7:0]  op, r;
        logic [31:0] sr_frame;
        int          wr_base, rd_base, n_wr, n_pop;
        op       = fr[0];
        wr_base  = wr_q.size();
        rd_base  = rd_ptr;
        sr_frame = disk_sr;
        spi_cs_n = 1'b0;
        #50;
        for (int i = 0; i <= k; i++) begin
            spi_bits(fr[i], 8, r);
            miso_rx[i] = r;
            if (i == 0) disk_sr = $urandom;
        end
        if (part_bits > 0) spi_bits(fr[k+1], part_bits, r);
        #50;
        spi_cs_n = 1'b1;
        #100;
        for (int i = 0; i <= k; i++)
            check_eq($sformatf("miso op%02h byte%0d", op, i), {24'h0, miso_rx[i]},
                     {24'h0, exp_miso(op, i, rd_base, sr_frame)});
        if (op == 8'h02 && k >= 4) cr_exp = {fr[1], fr[2], fr[3], fr[4]};
        check_eq($sformatf("disk_cr op%02h", op), disk_cr, cr_exp);
        n_wr  = (op == 8'h03) ? ((k < SECTOR) ? k : SECTOR) : 0;
        n_pop = (op == 8'h04) ? ((k + 1 < SECTOR) ? k + 1 : SECTOR) : 0;
        check_eq($sformatf("wr_count op%02h", op), wr_q.size() - wr_base, n_wr);
        for (int j = 0; j < n_wr; j++)
            if (wr_base + j < wr_q.size())
                check_eq($sformatf("wr_data %0d", j), {24'h0, wr_q[wr_base+j]}, {24'h0, fr[j+1]});
        check_eq($sformatf("pop_count op%02h", op), rd_ptr - rd_base, n_pop);
        check_eq("miso_idle", {31'h0, spi_miso}, 32'h1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int         k, wr_base, rd_base;
        for (int i = 0; i < 2048; i++) rd_src[i] = 8'($urandom);

        #52;
        check_eq("rst_cr", disk_cr, 32'h0);
        check_eq("rst_miso", {31'h0, spi_miso}, 32'h1);
        check_eq("rst_clkin", {31'h0, disk_data_clkin}, 32'h0);
        check_eq("rst_clkout", {31'h0, disk_data_clkout}, 32'h0);
        check_eq("rst_data_in", {24'h0, disk_data_in}, 32'h0);
        rst_n = 1'b1;
        #100;

        disk_sr = 32'h12345678;
        fr[0] = 8'h01;
        for (int i = 1; i <= 4; i++) fr[i] = 8'($urandom);
        run_frame(4, 0);

        fr[0] = 8'h02; fr[1] = 8'hDE; fr[2] = 8'hAD; fr[3] = 8'hBE; fr[4] = 8'hEF;
        run_frame(4, 0);
        check_eq("cr_deadbeef", disk_cr, 32'hDEADBEEF);
        fr[0] = 8'h02; fr[1] = 8'h11; fr[2] = 8'h22; fr[3] = 8'h33;
        run_frame(2, 5);

        for (int i = 0; i < 4; i++) rd_src[(rd_ptr + i) % 2048] = 8'hA0 + 8'(i);
        fr[0] = 8'h04;
        for (int i = 1; i <= 4; i++) fr[i] = 8'($urandom);
        run_frame(4, 0);

        fr[0] = 8'h7E;
        for (int i = 1; i <= 3; i++) fr[i] = 8'($urandom);
        run_frame(3, 0);

        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 5))
                0:       fr[0] = 8'h01;
                1:       fr[0] = 8'h02;
                2:       fr[0] = 8'h03;
                3:       fr[0] = 8'h04;
                default: fr[0] = 8'($urandom_range(5, 255));
            endcase
            disk_sr = $urandom;
            k = $urandom_range(0, 7);
            for (int i = 1; i <= k + 1; i++) fr[i] = 8'($urandom);
            run_frame(k, $urandom_range(0, 7));
        end

        // sclk activity with cs_n high must be ignored
        wr_base = wr_q.size();
        rd_base = rd_ptr;
        for (int i = 0; i < 16; i++) begin
            spi_mosi = 1'($urandom);
            #50 spi_sclk = 1'b1;
            #50 spi_sclk = 1'b0;
        end
        #50;
        check_eq("cs_high_wr", wr_q.size() - wr_base, 0);
        check_eq("cs_high_pop", rd_ptr - rd_base, 0);
        check_eq("cs_high_miso", {31'h0, spi_miso}, 32'h1);
        check_eq("cs_high_cr", disk_cr, cr_exp);

        fr[0] = 8'h03;
        for (int i = 1; i <= 513; i++) fr[i] = 8'((i - 1) % 256);
        run_frame(513, 0);

        // reset in the middle of a WRDATA byte
        wr_base = wr_q.size();
        spi_cs_n = 1'b0;
        #50;
        spi_bits(8'h03, 8, r);
        spi_bits(8'hA5, 4, r);
        #20;
        rst_n = 1'b0;
        cr_exp = 32'h0;
        #30;
        check_eq("midrst_miso", {31'h0, spi_miso}, 32'h1);
        check_eq("midrst_cr", disk_cr, 32'h0);
        spi_cs_n = 1'b1;
        #40;
        rst_n = 1'b1;
        #100;
        check_eq("midrst_wr", wr_q.size() - wr_base, 0);
        check_eq("midrst_miso_after", {31'h0, spi_miso}, 32'h1);

        disk_sr = $urandom;
        fr[0] = 8'h01;
        for (int i = 1; i <= 5; i++) fr[i] = 8'($urandom);
        run_frame(5, 0);
        fr[0] = 8'h03;
        for (int i = 1; i <= 3; i++) fr[i] = 8'($urandom);
        run_frame(2, 3);

        check_eq("strobes_overlap", both_cnt, 0);
        check_eq("clkin_width", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
